// File: rtl/ring_seq_if.sv
// Bus bundle for the ring/Johnson sequencer: control inputs and registered
// state outputs. Control semantics: en and load are single-cycle qualifiers
// sampled on every rising clk edge; there is no back-pressure, the sequencer
// accepts every request on the edge where it is sampled and the result is
// visible on cnt/pos/wrap/err right after that same edge.
interface ring_seq_if #(
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(2 * WIDTH);

  logic             en;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    pos;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, mode, load, load_val,
    input  cnt, pos, wrap, err
  );

  modport slave (
    input  en, dir, mode, load, load_val,
    output cnt, pos, wrap, err
  );
endinterface

// File: rtl/ring_seq.sv
// One-hot ring / Johnson sequencer with direction control, enable, parallel
// load and illegal-state recovery. Reports the step index and wrap/err pulses.
module ring_seq #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  ring_seq_if.slave  bus
);
  localparam int PW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic             mode_q, mode_d;

  logic [PW-1:0]    last_pos;
  logic [PW-1:0]    pos_inc;
  logic [PW-1:0]    pos_dec;
  logic [WIDTH-1:0] step_cnt;

  // Ring: exactly one bit set. Johnson: at most one adjacent bit pair differs.
  function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic johnson);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) ones++;
    end
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) edges++;
    end
    return johnson ? (edges <= 1) : (ones == 1);
  endfunction

  // Step index implied by a legal state value.
  function automatic logic [PW-1:0] decode(input logic [WIDTH-1:0] v, input logic johnson);
    int ones;
    int idx;
    int p;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        ones++;
        idx = i;
      end
    end
    if (johnson) begin
      if (v[WIDTH-1])     p = ones;
      else if (ones == 0) p = 0;
      else                p = 2 * WIDTH - ones;
    end else begin
      p = (idx == 0) ? 0 : WIDTH - idx;
    end
    return PW'(p);
  endfunction

  function automatic logic [WIDTH-1:0] home(input logic johnson);
    return johnson ? '0 : WIDTH'(1);
  endfunction

  // Next-step candidates for cnt and pos in the current mode and direction.
  always_comb begin
    last_pos = mode_q ? PW'(2 * WIDTH - 1) : PW'(WIDTH - 1);
    pos_inc  = (pos_q == last_pos) ? '0 : pos_q + PW'(1);
    pos_dec  = (pos_q == '0) ? last_pos : pos_q - PW'(1);
    step_cnt = cnt_q;
    case ({mode_q, bus.dir})
      2'b00:   step_cnt = {cnt_q[0], cnt_q[WIDTH-1:1]};
      2'b01:   step_cnt = {cnt_q[WIDTH-2:0], cnt_q[WIDTH-1]};
      2'b10:   step_cnt = {~cnt_q[0], cnt_q[WIDTH-1:1]};
      default: step_cnt = {cnt_q[WIDTH-2:0], ~cnt_q[WIDTH-1]};
    endcase
  end

  // Priority: mode change, load, illegal-state recovery, step, hold.
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    mode_d = mode_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (bus.mode != mode_q) begin
      mode_d = bus.mode;
      cnt_d  = home(bus.mode);
      pos_d  = '0;
    end else if (bus.load) begin
      if (is_legal(bus.load_val, mode_q)) begin
        cnt_d = bus.load_val;
        pos_d = decode(bus.load_val, mode_q);
      end else begin
        cnt_d = home(mode_q);
        pos_d = '0;
        err_d = 1'b1;
      end
    end else if (!is_legal(cnt_q, mode_q)) begin
      cnt_d = home(mode_q);
      pos_d = '0;
      err_d = 1'b1;
    end else if (bus.en) begin
      cnt_d  = step_cnt;
      pos_d  = bus.dir ? pos_dec : pos_inc;
      wrap_d = bus.dir ? (pos_dec == '0) : (pos_inc == '0);
    end
  end

  // State registers with synchronous active-low reset to ring home.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= WIDTH'(1);
      pos_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
      mode_q <= mode_d;
    end
  end

  assign bus.cnt  = cnt_q;
  assign bus.pos  = pos_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_ring_seq.sv
// Bench for ring_seq: directed sequences with literal expectations, then
// randomized traffic compared every cycle against a step-index model.
module tb_ring_seq;
  localparam int W = 8;

  logic clk;
  logic rst;
  ring_seq_if #(.WIDTH(W)) bus();

  ring_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;
  logic chk_on;

  // Literal expectations for the cycle that follows the current drive.
  logic         pin_on;
  logic [W-1:0] pin_cnt;
  int           pin_pos;
  logic         pin_wrap;
  logic         pin_err;

  // Illegal-state injection handshake to the model.
  int           inj_cnt;
  int           inj_seen;
  logic [W-1:0] inj_val;

  // Model state
  logic [W-1:0] m_cnt;
  int           m_pos;
  logic         m_mode;
  logic         m_wrap;
  logic         m_err;
  int           m_tmp;

  // State value for step index p: ring one-hot, Johnson run of ones.
  function automatic logic [W-1:0] image(input logic j, input int p);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (j) v[i] = (p <= W) ? (i >= W - p) : (i < 2 * W - p);
      else   v[i] = (i == (W - p) % W);
    end
    return v;
  endfunction

  // Index whose image equals v, or -1 when v is not a legal state.
  function automatic int find_pos(input logic [W-1:0] v, input logic j);
    int per;
    per = j ? 2 * W : W;
    for (int p = 0; p < per; p++) begin
      if (image(j, p) == v) return p;
    end
    return -1;
  endfunction

  // Behavioural model advancing on each rising edge.
  always @(posedge clk) begin
    if (inj_cnt != inj_seen) begin
      m_cnt    = inj_val;
      inj_seen = inj_cnt;
    end
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (!rst) begin
      m_cnt  = W'(1);
      m_pos  = 0;
      m_mode = 1'b0;
    end else if (bus.mode != m_mode) begin
      m_mode = bus.mode;
      m_pos  = 0;
      m_cnt  = image(m_mode, 0);
    end else if (bus.load) begin
      m_tmp = find_pos(bus.load_val, m_mode);
      if (m_tmp >= 0) begin
        m_cnt = bus.load_val;
        m_pos = m_tmp;
      end else begin
        m_pos = 0;
        m_cnt = image(m_mode, 0);
        m_err = 1'b1;
      end
    end else if (find_pos(m_cnt, m_mode) < 0) begin
      m_pos = 0;
      m_cnt = image(m_mode, 0);
      m_err = 1'b1;
    end else if (bus.en) begin
      m_tmp  = m_mode ? 2 * W : W;
      m_pos  = bus.dir ? (m_pos + m_tmp - 1) % m_tmp : (m_pos + 1) % m_tmp;
      m_cnt  = image(m_mode, m_pos);
      m_wrap = (m_pos == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: model every cycle, literal pins when armed.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cnt", 32'(bus.cnt), 32'(m_cnt));
      check("pos", 32'(bus.pos), 32'(m_pos));
      check("wrap", 32'(bus.wrap), 32'(m_wrap));
      check("err", 32'(bus.err), 32'(m_err));
      if (pin_on) begin
        check("pin_cnt", 32'(bus.cnt), 32'(pin_cnt));
        check("pin_pos", 32'(bus.pos), 32'(pin_pos));
        check("pin_wrap", 32'(bus.wrap), 32'(pin_wrap));
        check("pin_err", 32'(bus.err), 32'(pin_err));
      end
    end
  end

  task automatic cyc(input logic r, input logic e, input logic d, input logic m,
                     input logic l, input logic [W-1:0] lv, input logic pn,
                     input logic [W-1:0] ec, input int ep, input logic ew, input logic ee);
    @(negedge clk);
    #1;
    rst          = r;
    bus.en       = e;
    bus.dir      = d;
    bus.mode     = m;
    bus.load     = l;
    bus.load_val = lv;
    pin_on       = pn;
    pin_cnt      = ec;
    pin_pos      = ep;
    pin_wrap     = ew;
    pin_err      = ee;
  endtask

  // Plant a state value in the DUT register just before the next edge.
  task automatic inject(input logic [W-1:0] v, input logic pn, input logic [W-1:0] ec,
                        input int ep, input logic ew, input logic ee);
    @(negedge clk);
    #1;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.load = 1'b0;
    pin_on   = pn;
    pin_cnt  = ec;
    pin_pos  = ep;
    pin_wrap = ew;
    pin_err  = ee;
    inj_val  = v;
    inj_cnt++;
    force dut.cnt_q = v;
    #1;
    release dut.cnt_q;
  endtask

  logic [W-1:0] rseq [8];
  logic [W-1:0] jseq [16];
  logic [W-1:0] lv;
  logic         md;

  // Stimulus: directed sequences, then randomized traffic, then report.
  initial begin
    errs = 0; checks = 0; chk_on = 1'b0; pin_on = 1'b0;
    pin_cnt = '0; pin_pos = 0; pin_wrap = 1'b0; pin_err = 1'b0;
    inj_cnt = 0; inj_seen = 0; inj_val = '0;
    rst = 1'b0; bus.en = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.load = 1'b0; bus.load_val = '0;
    rseq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    jseq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
             8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
    repeat (2) @(posedge clk);
    chk_on = 1'b1;

    cyc(0, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0, 8'h00, 1, rseq[i], (i + 1) % 8, i == 7, 0);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1, 0, 8'h00, 1, jseq[i], (i + 1) % 16, i == 15, 0);
    cyc(1, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 8'h00, 1, 8'h02, 7, 0, 0);
    cyc(1, 1, 0, 0, 0, 8'h00, 1, 8'h01, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 8'h10, 1, 8'h10, 4, 0, 0);
    cyc(1, 0, 0, 0, 1, 8'h03, 1, 8'h01, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    cyc(1, 1, 0, 0, 1, 8'h20, 1, 8'h20, 3, 0, 0);
    cyc(1, 0, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 8'h0F, 1, 8'h0F, 12, 0, 0);
    inject(8'h5A, 1, 8'h00, 0, 0, 1);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'h80, 1, 0, 0);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'hC0, 2, 0, 0);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'hE0, 3, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0, 8'h00, 1, 8'hE0, 3, 0, 0);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'hF0, 4, 0, 0);
    cyc(1, 1, 0, 1, 0, 8'h00, 1, 8'hF8, 5, 0, 0);
    cyc(0, 1, 0, 1, 0, 8'h00, 1, 8'h01, 0, 0, 0);
    cyc(1, 0, 0, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      md = bus.mode;
      if ($urandom_range(0, 99) < 3) md = ~md;
      if ($urandom_range(0, 1) == 0)
        lv = image(md, int'($urandom_range(0, md ? 2 * W - 1 : W - 1)));
      else
        lv = W'($urandom);
      if ($urandom_range(0, 99) < 2) begin
        inject(W'($urandom), 0, 8'h00, 0, 0, 0);
      end else begin
        cyc($urandom_range(0, 99) != 0, $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
            md, $urandom_range(0, 99) < 10, lv, 0, 8'h00, 0, 0, 0);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
